// File: rtl/iob_axistream_in_mc_pkg.sv
// Shared types and width helpers for the multi-channel AXI-Stream input packer.
// Imported by the per-channel packer and the merging top level.
package iob_axistream_in_mc_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Channel-id width: a single channel still needs a 1-bit tid.
  function automatic int id_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int lane_idx_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/iob_axistream_in_mc_packer.sv
// Per-channel packer: gathers TDATA_W beats into a DATA_W word with lane keep bits,
// parks finished words in a one-entry hold register, and keeps beat/packet status.
module iob_axistream_in_mc_packer
  import iob_axistream_in_mc_pkg::*;
#(
  parameter  int TDATA_W = 8,
  parameter  int DATA_W  = 32,
  parameter  int CNT_W   = 16,
  localparam int R       = DATA_W / TDATA_W,
  localparam int R_W     = lane_idx_width(R)
) (
  input  logic               clk_i,
  input  logic               cke_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic               s_tvalid_i,
  input  logic [TDATA_W-1:0] s_tdata_i,
  input  logic               s_tlast_i,
  output logic               s_tready_o,
  input  logic               hold_pop_i,
  output logic               hold_v_o,
  output logic [DATA_W-1:0]  hold_data_o,
  output logic [R-1:0]       hold_keep_o,
  output logic               hold_last_o,
  output logic [CNT_W-1:0]   nwords_o,
  output logic               pkt_done_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] word_next;
  logic [R-1:0]      keep;
  logic [R-1:0]      keep_next;
  logic [R_W-1:0]    idx;
  logic              accept;
  logic              complete;

  // A beat may enter while the hold slot is free or is being drained this cycle.
  assign s_tready_o = en_i & (~hold_v_o | hold_pop_i);
  assign accept     = cke_i & s_tvalid_i & s_tready_o;
  assign complete   = (idx == R_W'(R - 1)) | s_tlast_i;

  always_comb begin
    word_next = acc;
    keep_next = keep;
    for (int k = 0; k < R; k++) begin
      if (idx == R_W'(k)) begin
        word_next[k*TDATA_W +: TDATA_W] = s_tdata_i;
        keep_next[k]                    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc         <= '0;
      keep        <= '0;
      idx         <= '0;
      hold_v_o    <= 1'b0;
      hold_data_o <= '0;
      hold_keep_o <= '0;
      hold_last_o <= 1'b0;
    end else if (cke_i) begin
      if (hold_pop_i) hold_v_o <= 1'b0;
      if (accept) begin
        if (complete) begin
          hold_v_o    <= 1'b1;
          hold_data_o <= word_next;
          hold_keep_o <= keep_next;
          hold_last_o <= s_tlast_i;
          acc         <= '0;
          keep        <= '0;
          idx         <= '0;
        end else begin
          acc  <= word_next;
          keep <= keep_next;
          idx  <= idx + 1'b1;
        end
      end
    end
  end

  // A clear in the same cycle as an accepted beat wipes history first, then counts the beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nwords_o   <= '0;
      pkt_done_o <= 1'b0;
    end else if (cke_i) begin
      if (clr_i) begin
        nwords_o   <= accept ? CNT_W'(1) : '0;
        pkt_done_o <= accept & s_tlast_i;
      end else if (accept) begin
        if (nwords_o != CNT_MAX) nwords_o <= nwords_o + 1'b1;
        if (s_tlast_i) pkt_done_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_axistream_in_mc.sv
// N-channel AXI-Stream input packer/merger: per-channel packers feed a packet-locked
// round-robin arbiter that drives a single registered AXIS master with tid/tkeep/tlast.
module iob_axistream_in_mc
  import iob_axistream_in_mc_pkg::*;
#(
  parameter  int N_CH    = 2,
  parameter  int TDATA_W = 8,
  parameter  int DATA_W  = 32,
  parameter  int CNT_W   = 16,
  localparam int R       = DATA_W / TDATA_W,
  localparam int ID_W    = id_width(N_CH)
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic [N_CH-1:0]         en_i,
  input  logic [N_CH-1:0]         clr_i,
  input  logic [N_CH-1:0]         s_tvalid_i,
  input  logic [N_CH*TDATA_W-1:0] s_tdata_i,
  input  logic [N_CH-1:0]         s_tlast_i,
  output logic [N_CH-1:0]         s_tready_o,
  output logic                    m_tvalid_o,
  output logic [DATA_W-1:0]       m_tdata_o,
  output logic [R-1:0]            m_tkeep_o,
  output logic                    m_tlast_o,
  output logic [ID_W-1:0]         m_tid_o,
  input  logic                    m_tready_i,
  output logic [N_CH*CNT_W-1:0]   nwords_o,
  output logic [N_CH-1:0]         pkt_done_o
);

  logic [N_CH-1:0]   hold_v;
  logic [N_CH-1:0]   hold_last;
  logic [N_CH-1:0]   hold_pop;
  logic [DATA_W-1:0] hold_data [N_CH];
  logic [R-1:0]      hold_keep [N_CH];

  arb_state_t        state;
  arb_state_t        state_next;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_next;
  logic [ID_W-1:0]   grant_ch;
  logic [ID_W-1:0]   cand;
  logic              grant_v;
  logic              load;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      iob_axistream_in_mc_packer #(
        .TDATA_W (TDATA_W),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
      ) u_packer (
        .clk_i       (clk_i),
        .cke_i       (cke_i),
        .rst_i       (rst_i),
        .en_i        (en_i[c]),
        .clr_i       (clr_i[c]),
        .s_tvalid_i  (s_tvalid_i[c]),
        .s_tdata_i   (s_tdata_i[c*TDATA_W +: TDATA_W]),
        .s_tlast_i   (s_tlast_i[c]),
        .s_tready_o  (s_tready_o[c]),
        .hold_pop_i  (hold_pop[c]),
        .hold_v_o    (hold_v[c]),
        .hold_data_o (hold_data[c]),
        .hold_keep_o (hold_keep[c]),
        .hold_last_o (hold_last[c]),
        .nwords_o    (nwords_o[c*CNT_W +: CNT_W]),
        .pkt_done_o  (pkt_done_o[c])
      );
      assign hold_pop[c] = load & (grant_ch == ID_W'(c));
    end
  endgenerate

  assign load = cke_i & (~m_tvalid_o | m_tready_i) & grant_v;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
      ptr   <= '0;
    end else if (cke_i) begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The pointer doubles as the locked channel, so a lock needs no extra register.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      ARB_IDLE: begin
        if (grant_v) begin
          ptr_next = grant_ch;
          if (!(load && hold_last[grant_ch])) state_next = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (load && hold_last[ptr]) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Descending scan lets the channel closest after ptr win without a found flag.
  always_comb begin
    grant_v  = 1'b0;
    grant_ch = ptr;
    cand     = ptr;
    if (state == ARB_LOCKED) begin
      grant_v = hold_v[ptr];
    end else begin
      for (int i = N_CH; i >= 1; i--) begin
        cand = ID_W'((int'(ptr) + i) % N_CH);
        if (hold_v[cand]) begin
          grant_v  = 1'b1;
          grant_ch = cand;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tkeep_o  <= '0;
      m_tlast_o  <= 1'b0;
      m_tid_o    <= '0;
    end else if (cke_i) begin
      if (load) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= hold_data[grant_ch];
        m_tkeep_o  <= hold_keep[grant_ch];
        m_tlast_o  <= hold_last[grant_ch];
        m_tid_o    <= grant_ch;
      end else if (m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end
    end
  end

endmodule
